ddr_port_arbiter: RTL

- Shares the single DDR read engine (uip2axi_rd_*) and single DDR write engine (uip2axi_wr_*) between NUM_REQ requesters, e.g. graph_conv feature fetch/writeback and the stream-clean content-clear engine.
- Read and write channels are arbitrated independently, each with round-robin priority.
- The block sits between the requesters and the AXI master IP. Each requester keeps the existing level-en/pulse-done protocol.

---
 rtl/ddr_port_arbiter_pkg.sv | 15 +
 rtl/ddr_port_arbiter_chan.sv | 111 +++++++++++
 rtl/ddr_port_arbiter.sv | 89 ++++++++
 3 files changed

// File: rtl/ddr_port_arbiter_pkg.sv
// Shared types and constants for the DDR port arbiter.
package aegnn_pkg;

  // Largest requester count a channel arbiter supports.
  localparam int NUM_REQ_MAX = 4;

  // Per-channel arbiter states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/ddr_port_arbiter_chan.sv
// One DDR channel arbiter: round-robin select, grant, latched payload,
// done routing back to the owner and a sticky protocol error flag.
module ddr_chan_arb
  import aegnn_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int PAYLOAD_W = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic [NUM_REQ-1:0]           i_req_en,
  input  logic [NUM_REQ*PAYLOAD_W-1:0] i_req_payload,
  input  logic                         i_axi_done,
  output logic                         o_axi_en,
  output logic [PAYLOAD_W-1:0]         o_axi_payload,
  output logic [NUM_REQ-1:0]           o_grant,
  output logic [NUM_REQ-1:0]           o_req_done,
  output logic                         o_protocol_err
);

  localparam int PTR_W = $clog2(NUM_REQ_MAX);

  arb_state_e           r_state;
  logic [PTR_W-1:0]     r_ptr;
  logic [PTR_W-1:0]     r_gidx;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   r_done;
  logic                 r_en;
  logic                 r_perr;
  logic [PAYLOAD_W-1:0] r_payload;

  logic [NUM_REQ-1:0]   w_rot;
  logic [PTR_W-1:0]     w_pick;
  logic [PTR_W-1:0]     w_next_ptr;
  logic [PAYLOAD_W-1:0] w_sel_payload;

  // Requester index ptr+offset folded back into 0..NUM_REQ-1.
  function automatic logic [PTR_W-1:0] rr_wrap(input int v);
    return (v >= NUM_REQ) ? PTR_W'(v - NUM_REQ) : PTR_W'(v);
  endfunction

  // Rotate requests so bit 0 is the pointer's requester; lowest set bit wins.
  always_comb begin
    w_rot  = NUM_REQ'({i_req_en, i_req_en} >> r_ptr);
    w_pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_pick = rr_wrap(int'(r_ptr) + i);
    end
  end

  // Payload of the requester being picked, plus the pointer after the owner.
  always_comb begin
    w_sel_payload = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick == PTR_W'(i)) w_sel_payload = i_req_payload[i*PAYLOAD_W +: PAYLOAD_W];
    end
    w_next_ptr = (r_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : r_gidx + PTR_W'(1);
  end

  // Channel FSM: IDLE -> ISSUE -> WAIT_DONE -> RELEASE -> IDLE.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gidx    <= '0;
      r_grant   <= '0;
      r_done    <= '0;
      r_en      <= 1'b0;
      r_perr    <= 1'b0;
      r_payload <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (|i_req_en) begin
            r_grant   <= NUM_REQ'(1) << w_pick;
            r_gidx    <= w_pick;
            r_payload <= w_sel_payload;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          r_en    <= 1'b1;
          r_state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (i_axi_done) begin
            r_done  <= r_grant;
            r_en    <= 1'b0;
            r_ptr   <= w_next_ptr;
            r_state <= RELEASE;
          end
        end
        RELEASE: begin
          r_grant <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // A done outside WAIT_DONE is a slave protocol violation; remember it.
      if (i_axi_done && (r_state != WAIT_DONE)) r_perr <= 1'b1;
    end
  end

  assign o_axi_en       = r_en;
  assign o_axi_payload  = r_payload;
  assign o_grant        = r_grant;
  assign o_req_done     = r_done;
  assign o_protocol_err = r_perr;

endmodule

// File: rtl/ddr_port_arbiter.sv
// Shares one DDR read engine and one DDR write engine between NUM_REQ
// requesters; the two channels arbitrate independently.
module ddr_port_arbiter
  import aegnn_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_BUF_LEN = 1024,
  parameter int WR_BUF_LEN = 1024
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_rd_en,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rd_addr,
  output logic [NUM_REQ-1:0]            req_rd_done,
  output logic [RD_BUF_LEN-1:0]         req_rd_buffer,
  input  logic [NUM_REQ-1:0]            req_wr_en,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_wr_addr,
  input  logic [NUM_REQ*WR_BUF_LEN-1:0] req_wr_buffer,
  output logic [NUM_REQ-1:0]            req_wr_done,
  output logic                          uip2axi_rd_en,
  input  logic                          axi2uip_rd_done,
  output logic [ADDR_WIDTH-1:0]         uip2axi_rd_addr,
  input  logic [RD_BUF_LEN-1:0]         rd_buffer,
  output logic                          uip2axi_wr_en,
  input  logic                          axi2uip_wr_done,
  output logic [ADDR_WIDTH-1:0]         uip2axi_wr_addr,
  output logic [WR_BUF_LEN-1:0]         wr_buffer,
  output logic [NUM_REQ-1:0]            rd_grant,
  output logic [NUM_REQ-1:0]            wr_grant,
  output logic                          protocol_err
);

  localparam int WR_PAY_W = ADDR_WIDTH + WR_BUF_LEN;

  logic [NUM_REQ*WR_PAY_W-1:0] w_wr_pack;
  logic [WR_PAY_W-1:0]         w_wr_pay;
  logic                        w_rd_perr;
  logic                        w_wr_perr;
  logic [RD_BUF_LEN-1:0]       r_rd_buffer;

  // Each write requester's payload is {address, data}.
  always_comb begin
    w_wr_pack = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_wr_pack[i*WR_PAY_W +: WR_PAY_W] = {req_wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                                          req_wr_buffer[i*WR_BUF_LEN +: WR_BUF_LEN]};
    end
  end

  ddr_chan_arb #(.NUM_REQ(NUM_REQ), .PAYLOAD_W(ADDR_WIDTH)) u_rd_arb (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_req_en       (req_rd_en),
    .i_req_payload  (req_rd_addr),
    .i_axi_done     (axi2uip_rd_done),
    .o_axi_en       (uip2axi_rd_en),
    .o_axi_payload  (uip2axi_rd_addr),
    .o_grant        (rd_grant),
    .o_req_done     (req_rd_done),
    .o_protocol_err (w_rd_perr)
  );

  ddr_chan_arb #(.NUM_REQ(NUM_REQ), .PAYLOAD_W(WR_PAY_W)) u_wr_arb (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_req_en       (req_wr_en),
    .i_req_payload  (w_wr_pack),
    .i_axi_done     (axi2uip_wr_done),
    .o_axi_en       (uip2axi_wr_en),
    .o_axi_payload  (w_wr_pay),
    .o_grant        (wr_grant),
    .o_req_done     (req_wr_done),
    .o_protocol_err (w_wr_perr)
  );

  // Capture read data only for an accepted done; the read command is high
  // exactly while the channel waits for its done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_rd_buffer <= '0;
    else if (axi2uip_rd_done && uip2axi_rd_en) r_rd_buffer <= rd_buffer;
  end

  assign uip2axi_wr_addr = w_wr_pay[WR_PAY_W-1 -: ADDR_WIDTH];
  assign wr_buffer       = w_wr_pay[WR_BUF_LEN-1:0];
  assign req_rd_buffer   = r_rd_buffer;
  assign protocol_err    = w_rd_perr | w_wr_perr;

endmodule
